ifetch_unit: RTL and testbench

- Instruction-fetch responder that consumes the PC stream and turns each address into an instruction-memory request.
- Pairs each in-order memory response with its PC and buffers the result for the decode stage.
- Handles branch/jump redirects by flushing buffered instructions and discarding in-flight responses.
- Sits between the PC register and decode, and is the sole master of the instruction-memory port.

---
 rtl/ifetch_pkg.sv | 10 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/ifetch_unit.sv | 70 +++++++
 tb/tb_ifetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, NOP encoding and the buffered fetch entry type
package ifetch_pkg;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [IW-1:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry FIFO with flush, head word read straight from storage
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout = r_mem[r_rd];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + PW'(w_push);
      r_rd <= r_rd + PW'(w_pop);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: credit-limited instruction fetch pairing in-order memory responses with their PCs
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = ifetch_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_valid_i,
  output logic          pc_ready_o,
  input  logic          redirect_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [31:0]   imem_rdata_i,
  output logic          instr_valid_o,
  output logic [31:0]   instr_o,
  output logic [AW-1:0] instr_pc_o,
  input  logic          instr_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] r_outstanding, r_discard, w_buf_count, w_pend_count;
  logic w_credit, w_grant, w_live, w_buf_push, w_buf_pop;
  logic w_pend_full, w_pend_empty, w_buf_full, w_buf_empty;
  logic [AW-1:0] w_pend_pc;
  fetch_entry_t w_buf_din, w_head, r_last;
  assign w_credit = (CW+2)'(w_buf_count) + (CW+2)'(r_outstanding) + (CW+2)'(r_discard) < (CW+2)'(DEPTH);
  assign imem_req_o = rst_n & pc_valid_i & w_credit & ~redirect_i;
  assign imem_addr_o = {pc_i[AW-1:2], 2'b00};
  assign pc_ready_o = imem_req_o & imem_gnt_i;
  assign w_grant = pc_ready_o;
  assign w_live = imem_rvalid_i & (r_discard == '0);
  assign w_buf_push = w_live & ~redirect_i;
  assign w_buf_pop = instr_ready_i & ~redirect_i;
  assign w_buf_din = '{pc: w_pend_pc, instr: imem_rdata_i};
  assign instr_valid_o = ~w_buf_empty;
  assign instr_o = w_buf_empty ? r_last.instr : w_head.instr;
  assign instr_pc_o = w_buf_empty ? r_last.pc : w_head.pc;
  // pending queue is never flushed: discarded responses still pop their PC
  sync_fifo #(.DEPTH(DEPTH), .W(AW)) u_pend (
    .clk(clk), .rst_n(rst_n), .i_flush(1'b0), .i_push(w_grant), .i_pop(imem_rvalid_i),
    .i_din(pc_i), .o_dout(w_pend_pc), .o_full(w_pend_full), .o_empty(w_pend_empty), .o_count(w_pend_count)
  );
  sync_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_buf (
    .clk(clk), .rst_n(rst_n), .i_flush(redirect_i), .i_push(w_buf_push), .i_pop(w_buf_pop),
    .i_din(w_buf_din), .o_dout(w_head), .o_full(w_buf_full), .o_empty(w_buf_empty), .o_count(w_buf_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_outstanding <= '0;
      r_discard <= '0;
      r_last <= '{pc: '0, instr: NOP};
    end else begin
      if (!w_buf_empty) r_last <= w_head;
      if (redirect_i) begin
        r_outstanding <= '0;
        r_discard <= r_discard + r_outstanding - CW'(imem_rvalid_i);
      end else begin
        r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_live);
        if (imem_rvalid_i && !w_live) r_discard <= r_discard - CW'(1);
      end
    end
  assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid_i |-> (!w_pend_empty && (r_outstanding != '0 || r_discard != '0)));
  assert property (@(posedge clk) disable iff (!rst_n) !(w_grant && w_pend_full));
  assert property (@(posedge clk) disable iff (!rst_n) !(w_buf_push && w_buf_full));
  assert property (@(posedge clk) disable iff (!rst_n) w_pend_count == r_outstanding + r_discard);
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios against an in-order memory responder with programmable latency
module tb_ifetch_unit;
  logic clk, rst_n, pc_valid_i, pc_ready_o, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic instr_valid_o, instr_ready_i;
  logic [31:0] pc_i, imem_addr_o, imem_rdata_i, instr_o, instr_pc_o;
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
  logic [31:0] q_addr[$], got_pc[$], got_in[$];
  int q_due[$];

  ifetch_unit #(.DEPTH(2), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .redirect_i(redirect_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    #1;
    if (imem_req_o && imem_gnt_i) begin
      q_addr.push_back(imem_addr_o);
      q_due.push_back(cyc + lat);
    end
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      got_pc.push_back(instr_pc_o);
      got_in.push_back(instr_o);
    end
    @(negedge clk);
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid_i = 1;
      imem_rdata_i = 32'h1000_0000 + q_addr[0];
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rvalid_i = 0;
      imem_rdata_i = 0;
    end
  endtask

  task automatic drain(input int n);
    pc_valid_i = 0; redirect_i = 0; instr_ready_i = 1; imem_gnt_i = 1;
    repeat (n) step();
    got_pc.delete(); got_in.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; pc_valid_i = 1; pc_i = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req_o); end
    n_chk++; if (pc_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_pc_ready: got %b exp 0", pc_ready_o); end
    n_chk++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", instr_valid_o); end
    n_chk++; if ({instr_o, instr_pc_o} !== 64'h0) begin n_fail++; $display("FAIL rst_instr: got %h/%h exp 0/0", instr_o, instr_pc_o); end
    @(negedge clk);
    rst_n = 1; pc_valid_i = 0;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    int k = 0;
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      pc_valid_i = k < 4; pc_i = pcs[k & 3];
      #1;
      if (i < 2) begin
        n_chk++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_pc_ready c%0d: got %b exp 1", i, pc_ready_o); end
        n_chk++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_latency c%0d: got %b exp 0", i, instr_valid_o); end
      end
      if (i == 2) begin
        n_chk++; if ({instr_valid_o, instr_pc_o, instr_o} !== {1'b1, 32'h0, 32'h1000_0000}) begin n_fail++; $display("FAIL stream_first: got v=%b pc=%h i=%h exp 1/0/10000000", instr_valid_o, instr_pc_o, instr_o); end
      end
      if (pc_ready_o) k++;
      step();
    end
    n_chk++; if (k !== 4) begin n_fail++; $display("FAIL stream_accepted: got %0d exp 4", k); end
    n_chk++; if (got_pc.size() !== 4) begin n_fail++; $display("FAIL stream_count: got %0d exp 4", got_pc.size()); end
    for (int j = 0; j < 4 && j < got_pc.size(); j++) begin
      n_chk++; if ({got_pc[j], got_in[j]} !== {pcs[j], 32'h1000_0000 + pcs[j]}) begin n_fail++; $display("FAIL stream_pair%0d: got %h/%h exp %h/%h", j, got_pc[j], got_in[j], pcs[j], 32'h1000_0000 + pcs[j]); end
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'h0};
    int k = 0, grants = 0;
    lat = 1; instr_ready_i = 0;
    for (int i = 0; i < 6; i++) begin
      pc_valid_i = k < 3; pc_i = pcs[k & 3];
      #1;
      if (pc_ready_o) begin grants++; k++; end
      step();
    end
    pc_valid_i = 1; pc_i = pcs[k & 3];
    #1;
    n_chk++; if (grants !== 2) begin n_fail++; $display("FAIL bp_grants: got %0d exp 2", grants); end
    n_chk++; if ({imem_req_o, pc_ready_o} !== 2'b00) begin n_fail++; $display("FAIL bp_stall: got req=%b rdy=%b exp 0/0", imem_req_o, pc_ready_o); end
    n_chk++; if ({instr_valid_o, instr_pc_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bp_head: got %b/%h exp 1/0", instr_valid_o, instr_pc_o); end
    step();
    instr_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      pc_valid_i = k < 3; pc_i = pcs[k & 3];
      #1;
      if (i == 0) begin
        n_chk++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_release0: got %h exp 0", instr_pc_o); end
      end
      if (i == 1) begin
        n_chk++; if ({imem_req_o, imem_addr_o, instr_pc_o} !== {1'b1, 32'h8, 32'h4}) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h pc=%h exp 1/8/4", imem_req_o, imem_addr_o, instr_pc_o); end
      end
      if (pc_ready_o) k++;
      step();
    end
    n_chk++; if (got_pc.size() !== 3) begin n_fail++; $display("FAIL bp_count: got %0d exp 3", got_pc.size()); end
    for (int j = 0; j < 3 && j < got_pc.size(); j++) begin
      n_chk++; if (got_pc[j] !== pcs[j]) begin n_fail++; $display("FAIL bp_order%0d: got %h exp %h", j, got_pc[j], pcs[j]); end
    end
    drain(4);
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] pcs [2] = '{32'h10, 32'h14};
    bit acc = 0;
    lat = 3;
    for (int i = 0; i < 2; i++) begin
      pc_valid_i = 1; pc_i = pcs[i];
      #1;
      n_chk++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL ri_grant%0d: got %b exp 1", i, pc_ready_o); end
      step();
    end
    pc_i = 32'h100; redirect_i = 1;
    #1;
    n_chk++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL ri_noreq: got %b exp 0", imem_req_o); end
    step();
    redirect_i = 0;
    for (int i = 0; i < 14; i++) begin
      pc_valid_i = !acc;
      #1;
      if (i == 0) begin
        n_chk++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL ri_discard_credit: got %b exp 0", imem_req_o); end
      end
      if (pc_ready_o) acc = 1;
      step();
    end
    n_chk++; if (got_pc.size() !== 1) begin n_fail++; $display("FAIL ri_count: got %0d exp 1", got_pc.size()); end
    if (got_pc.size() > 0) begin
      n_chk++; if ({got_pc[0], got_in[0]} !== {32'h100, 32'h1000_0100}) begin n_fail++; $display("FAIL ri_first: got %h/%h exp 100/10000100", got_pc[0], got_in[0]); end
    end
    lat = 1;
    drain(4);
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] pcs [2] = '{32'h40, 32'h44};
    bit acc = 0;
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      pc_valid_i = 1; pc_i = pcs[i];
      #1;
      n_chk++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL rc_grant%0d: got %b exp 1", i, pc_ready_o); end
      step();
    end
    pc_i = 32'h48; redirect_i = 1; instr_ready_i = 1;
    #1;
    n_chk++; if ({instr_valid_o, instr_pc_o, imem_req_o} !== {1'b1, 32'h40, 1'b0}) begin n_fail++; $display("FAIL rc_cycle: got v=%b pc=%h req=%b exp 1/40/0", instr_valid_o, instr_pc_o, imem_req_o); end
    step();
    redirect_i = 0;
    #1;
    n_chk++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rc_flush: got %b exp 0", instr_valid_o); end
    n_chk++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h48}) begin n_fail++; $display("FAIL rc_refetch: got %b/%h exp 1/48", imem_req_o, imem_addr_o); end
    for (int i = 0; i < 8; i++) begin
      pc_valid_i = !acc;
      #1;
      if (pc_ready_o) acc = 1;
      step();
    end
    n_chk++; if (got_pc.size() !== 1) begin n_fail++; $display("FAIL rc_count: got %0d exp 1", got_pc.size()); end
    if (got_pc.size() > 0) begin
      n_chk++; if (got_pc[0] !== 32'h48) begin n_fail++; $display("FAIL rc_first: got %h exp 48", got_pc[0]); end
    end
    drain(4);
  endtask

  task automatic test_grant_stall();
    lat = 1; pc_valid_i = 1; pc_i = 32'h20; imem_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({imem_req_o, imem_addr_o, pc_ready_o} !== {1'b1, 32'h20, 1'b0}) begin n_fail++; $display("FAIL gs_stall%0d: got req=%b addr=%h rdy=%b exp 1/20/0", i, imem_req_o, imem_addr_o, pc_ready_o); end
      step();
    end
    imem_gnt_i = 1;
    #1;
    n_chk++; if (pc_ready_o !== 1'b1) begin n_fail++; $display("FAIL gs_accept: got %b exp 1", pc_ready_o); end
    step();
    pc_valid_i = 0;
    repeat (4) step();
    n_chk++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h20) begin n_fail++; $display("FAIL gs_deliver: got n=%0d exp one instr at 20", got_pc.size()); end
    drain(2);
  endtask

  task automatic test_unaligned_reset();
    lat = 1; pc_valid_i = 1; pc_i = 32'h23; imem_gnt_i = 0;
    #1;
    n_chk++; if (imem_addr_o !== 32'h20) begin n_fail++; $display("FAIL ua_addr: got %h exp 20", imem_addr_o); end
    imem_gnt_i = 1;
    step();
    pc_valid_i = 0;
    repeat (4) step();
    n_chk++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h23 || got_in[0] !== 32'h1000_0020) begin n_fail++; $display("FAIL ua_deliver: got n=%0d exp pc 23 instr 10000020", got_pc.size()); end
    drain(2);
    instr_ready_i = 0;
    pc_valid_i = 1; pc_i = 32'h60; step();
    pc_i = 32'h64; step();
    pc_valid_i = 0; step();
    #1;
    n_chk++; if ({instr_valid_o, instr_pc_o} !== {1'b1, 32'h60}) begin n_fail++; $display("FAIL ur_buffered: got %b/%h exp 1/60", instr_valid_o, instr_pc_o); end
    rst_n = 0; pc_valid_i = 1; pc_i = 32'h68;
    q_addr.delete(); q_due.delete(); imem_rvalid_i = 0; imem_rdata_i = 0;
    #1;
    n_chk++; if ({instr_valid_o, imem_req_o, pc_ready_o} !== 3'b000) begin n_fail++; $display("FAIL ur_immediate: got v=%b req=%b rdy=%b exp 0/0/0", instr_valid_o, imem_req_o, pc_ready_o); end
    n_chk++; if ({instr_o, instr_pc_o} !== 64'h0) begin n_fail++; $display("FAIL ur_outputs: got %h/%h exp 0/0", instr_o, instr_pc_o); end
    @(negedge clk);
    rst_n = 1; instr_ready_i = 1;
    #1;
    n_chk++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h68}) begin n_fail++; $display("FAIL ur_release: got %b/%h exp 1/68", imem_req_o, imem_addr_o); end
    step();
    pc_valid_i = 0;
    repeat (4) step();
    n_chk++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h68) begin n_fail++; $display("FAIL ur_refetch: got n=%0d exp one instr at 68", got_pc.size()); end
    drain(2);
  endtask

  initial begin
    rst_n = 0; pc_valid_i = 0; pc_i = 0; redirect_i = 0; imem_gnt_i = 1;
    imem_rvalid_i = 0; imem_rdata_i = 0; instr_ready_i = 1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_grant_stall();
    test_unaligned_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
